// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types for the uart transmit scheduler
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    GAP,
    WAIT,
    NEXT
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotating-priority picker, ptr has highest priority
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   ptr,
  output logic [GW-1:0]   gnt_idx,
  output logic            any
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [GW:0]       sum;

  // Rotate so bit 0 of req_rot is the requester at ptr.
  assign req_dbl = {req, req};
  assign req_rot = NREQ'(req_dbl >> ptr);

  always_comb begin
    sum = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        sum = {1'b0, ptr} + (GW+1)'(k);
        any = 1'b1;
      end
    end
    if (sum >= (GW+1)'(NREQ)) begin
      sum = sum - (GW+1)'(NREQ);
    end
    gnt_idx = sum[GW-1:0];
  end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin packet scheduler feeding one uart_tx
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int GW   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ack,
  output logic                   tx_start,
  output logic [BYTE_W-1:0]      tx_data,
  input  logic                   tx_rdy,
  output logic [GW-1:0]          grant_id,
  output logic                   busy,
  output logic                   pkt_done
);

  sched_state_t state, state_d;
  logic [GW-1:0] rr_ptr, rr_ptr_d, grant_id_d, win_idx;
  logic          last_q, last_d, win_any;
  logic [BYTE_W-1:0] lane_data [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane_data[i] = req_data[BYTE_W*i +: BYTE_W];
  end

  rr_arbiter #(.NREQ(NREQ), .GW(GW)) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt_idx (win_idx),
    .any     (win_any)
  );

  assign tx_data = lane_data[grant_id];
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      last_q   <= 1'b0;
    end else begin
      state    <= state_d;
      rr_ptr   <= rr_ptr_d;
      grant_id <= grant_id_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    grant_id_d = grant_id;
    last_d     = last_q;
    tx_start   = 1'b0;
    req_ack    = '0;
    pkt_done   = 1'b0;
    case (state)
      IDLE: begin
        if (win_any && tx_rdy) begin
          grant_id_d = win_idx;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start          = 1'b1;
        req_ack[grant_id] = 1'b1;
        last_d            = req_last[grant_id];
        state_d           = GAP;
      end
      // tx_rdy has not yet dropped in response to tx_start here.
      GAP: state_d = WAIT;
      WAIT: begin
        if (tx_rdy) begin
          if (last_q) begin
            pkt_done = 1'b1;
            rr_ptr_d = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + GW'(1);
            state_d  = IDLE;
          end else begin
            state_d = NEXT;
          end
        end
      end
      // The lock is held until the owner presents its next byte.
      NEXT: begin
        if (req[grant_id]) state_d = LAUNCH;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench with packet-level round-robin model
module tb_uart_tx_sched;

  localparam int NREQ = 3;
  localparam int GW   = $clog2(NREQ);

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } byte_t;

  typedef struct packed {
    logic [GW-1:0] gid;
    logic [7:0]    data;
    logic          last;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ack;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_rdy;
  logic [GW-1:0]     grant_id;
  logic              busy;
  logic              pkt_done;

  byte_t stim_q [NREQ][$];
  byte_t pend   [NREQ][$];
  exp_t  exp_q  [$];

  int checks = 0;
  int errors = 0;
  int model_ptr, pkts_exp, pkts_seen, busy_cnt, gap_mode;
  int gap [NREQ];
  logic tx_rdy_m, rdy_hold, long_busy, pending_last;
  logic st_s, busy_s;
  logic [NREQ-1:0] ack_s;

  uart_tx_sched #(.NREQ(NREQ), .GW(GW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .req_ack  (req_ack),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_rdy   (tx_rdy),
    .grant_id (grant_id),
    .busy     (busy),
    .pkt_done (pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  // Monitor: every launch or ack must match the next scoreboard entry.
  initial begin
    exp_t e;
    logic [NREQ-1:0] exp_ack;
    pending_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending_last = 1'b0;
      end else begin
        if (tx_start || req_ack != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_launch", 32'({tx_start, req_ack}), 32'(0));
          end else begin
            e = exp_q.pop_front();
            exp_ack = '0;
            exp_ack[e.gid] = 1'b1;
            chk("launch", 32'({tx_start, grant_id, tx_data, req_ack}),
                32'({1'b1, e.gid, e.data, exp_ack}));
            pending_last = e.last;
          end
        end
        if (pkt_done) begin
          chk("pkt_done", 32'({pending_last, tx_rdy}), 32'(2'b11));
          pending_last = 1'b0;
          pkts_seen++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // One clock: sample outputs mid-cycle, then drive uart model and requesters.
  task automatic step();
    byte_t b;
    @(negedge clk);
    st_s   = tx_start;
    ack_s  = req_ack;
    busy_s = busy;
    @(posedge clk);
    #1;
    if (st_s) begin
      tx_rdy_m = 1'b0;
      busy_cnt = long_busy ? 100000 : int'($urandom_range(1, 5));
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_rdy_m = 1'b1;
    end
    tx_rdy = tx_rdy_m && !rdy_hold;
    for (int i = 0; i < NREQ; i++) begin
      if (ack_s[i] && stim_q[i].size() > 0) begin
        b = stim_q[i].pop_front();
        if (!b.last) gap[i] = (gap_mode == 1) ? 15 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      end
      if (gap[i] > 0) begin
        gap[i]--;
        req[i] = 1'b0;
      end else if (stim_q[i].size() > 0) begin
        req[i] = 1'b1;
        req_data[8*i +: 8] = stim_q[i][0].data;
        req_last[i] = stim_q[i][0].last;
      end else begin
        req[i] = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
  endtask

  task automatic add_byte(input int lane, input logic [7:0] d, input logic l);
    pend[lane].push_back('{data: d, last: l});
  endtask

  task automatic add_pkt(input int lane, input int len);
    for (int j = 0; j < len; j++) add_byte(lane, 8'($urandom), j == len - 1);
  endtask

  // Reference: whole packets leave in round-robin order among lanes with work.
  task automatic commit();
    byte_t b;
    int w;
    forever begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && pend[(model_ptr + k) % NREQ].size() > 0) w = (model_ptr + k) % NREQ;
      end
      if (w < 0) break;
      do begin
        b = pend[w].pop_front();
        exp_q.push_back('{gid: GW'(w), data: b.data, last: b.last});
        stim_q[w].push_back(b);
      end while (!b.last && pend[w].size() > 0);
      model_ptr = (w + 1) % NREQ;
      pkts_exp++;
    end
  endtask

  function automatic bit lanes_empty();
    bit r = 1'b1;
    for (int i = 0; i < NREQ; i++) if (stim_q[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic run_idle(input string name);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 3000) begin
      step();
      n++;
      done = (exp_q.size() == 0) && !busy_s && lanes_empty();
    end
    chk({name, "_complete"}, 32'(done), 32'(1));
  endtask

  task automatic wait_launch(input string name);
    int n = 0;
    st_s = 1'b0;
    while (!st_s && n < 20) begin
      step();
      n++;
    end
    chk(name, 32'(st_s), 32'(1));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req = '0; req_data = '0; req_last = '0;
    tx_rdy = 1'b1; tx_rdy_m = 1'b1; rdy_hold = 1'b0; long_busy = 1'b0;
    gap_mode = 0; busy_cnt = 0; model_ptr = 0; pkts_exp = 0; pkts_seen = 0;
    for (int i = 0; i < NREQ; i++) gap[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_tx_start", 32'(tx_start), 32'(0));
    chk("rst_req_ack", 32'(req_ack), 32'(0));
    chk("rst_pkt_done", 32'(pkt_done), 32'(0));
    chk("rst_grant_id", 32'(grant_id), 32'(0));

    add_byte(0, 8'h55, 1'b1);
    commit();
    step();
    step();
    chk("lat_req_cycle", 32'(st_s), 32'(0));
    step();
    chk("lat_launch_cycle", 32'(st_s), 32'(1));
    run_idle("single");

    add_byte(0, 8'h01, 1'b0); add_byte(0, 8'h02, 1'b0); add_byte(0, 8'h03, 1'b1);
    add_byte(1, 8'hA5, 1'b1);
    commit();
    run_idle("contention");

    for (int p = 0; p < 4; p++) begin
      add_pkt(0, 1);
      add_pkt(1, 1);
    end
    commit();
    run_idle("fairness");

    rdy_hold = 1'b1;
    step();
    add_byte(2, 8'h3C, 1'b1);
    commit();
    n = 0;
    repeat (10) begin
      step();
      if (st_s) n++;
    end
    chk("rdy_low_no_launch", 32'(n), 32'(0));
    rdy_hold = 1'b0;
    step();
    step();
    chk("rdy_rise_cycle", 32'(st_s), 32'(0));
    step();
    chk("rdy_rise_launch", 32'(st_s), 32'(1));
    run_idle("rdy_low");

    long_busy = 1'b1;
    add_pkt(2, 3);
    commit();
    wait_launch("midrst_launch");
    repeat (3) step();
    chk("midrst_busy", 32'(busy_s), 32'(1));
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      stim_q[i].delete();
      pend[i].delete();
      gap[i] = 0;
    end
    exp_q.delete();
    req = '0; req_last = '0;
    model_ptr = 0; pkts_exp = 0; pkts_seen = 0;
    long_busy = 1'b0; busy_cnt = 0; tx_rdy_m = 1'b1; tx_rdy = 1'b1;
    #2;
    chk("midrst_tx_start", 32'(tx_start), 32'(0));
    chk("midrst_req_ack", 32'(req_ack), 32'(0));
    chk("midrst_pkt_done", 32'(pkt_done), 32'(0));
    chk("midrst_busy_low", 32'(busy), 32'(0));
    chk("midrst_grant_id", 32'(grant_id), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    gap_mode = 1;
    add_byte(0, 8'h11, 1'b0); add_byte(0, 8'h22, 1'b1);
    add_byte(1, 8'h99, 1'b1);
    commit();
    wait_launch("stall_first_launch");
    n = 0;
    repeat (12) begin
      step();
      if (st_s) n++;
    end
    chk("stall_no_launch", 32'(n), 32'(0));
    chk("stall_busy", 32'(busy_s), 32'(1));
    gap_mode = 0;
    run_idle("stall");

    for (int r = 0; r < 8; r++) begin
      gap_mode = 2;
      for (int i = 0; i < NREQ; i++) begin
        repeat ($urandom_range(0, 3)) add_pkt(i, int'($urandom_range(1, 4)));
      end
      commit();
      run_idle("random");
    end

    chk("pkt_count", 32'(pkts_seen), 32'(pkts_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
